// File: rtl/debug_view_pkg.sv
// Shared types and elaboration-time helpers for the LED debug viewer.
// Holds the display-mode encoding plus width/slice-count derivations.
package debug_view_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_FREEZE = 2'd2
  } mode_t;

  // Index width that never collapses to zero bits, so selectors stay declarable.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int n_slice_of(input int data_w, input int n_leds);
    return (data_w + n_leds - 1) / n_leds;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus counting debouncer for one board switch.
// Emits the accepted level and a single-cycle pulse on each accepted press.
module switch_debounce
  import debug_view_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Press
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);

  logic             sync_1_reg;
  logic             sync_2_reg;
  logic             level_reg;
  logic             press_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_1_reg <= 1'b0;
      sync_2_reg <= 1'b0;
      level_reg  <= 1'b0;
      press_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      sync_1_reg <= i_Raw;
      sync_2_reg <= sync_1_reg;
      press_reg  <= 1'b0;
      if (sync_2_reg == level_reg) begin
        count_reg <= '0;
      end else if (count_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Only the rising acceptance is a press; release flips silently.
        level_reg <= ~level_reg;
        press_reg <= ~level_reg;
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign o_Level = level_reg;
  assign o_Press = press_reg;

endmodule

// File: rtl/led_debug_view.sv
// Board LED viewer over packed CPU debug buses: manual source/slice stepping,
// timed auto-scroll over every slice of every source, and a frozen snapshot.
module led_debug_view
  import debug_view_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int N_SRC           = 3,
  parameter int N_LEDS          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCROLL_CYCLES   = 25000000
) (
  input  logic                                            i_Clk,
  input  logic                                            i_Rst,
  input  logic [N_SRC*DATA_W-1:0]                         i_Src_Bus,
  input  logic                                            i_Switch_1,
  input  logic                                            i_Switch_2,
  input  logic                                            i_Switch_3,
  input  logic                                            i_Switch_4,
  output logic [N_LEDS-1:0]                               o_LED,
  output logic [clog2_min1(N_SRC)-1:0]                    o_Src_Sel,
  output logic [clog2_min1(n_slice_of(DATA_W, N_LEDS))-1:0] o_Slice_Sel,
  output logic [1:0]                                      o_Mode
);

  localparam int N_SLICE = n_slice_of(DATA_W, N_LEDS);
  localparam int SRC_W   = clog2_min1(N_SRC);
  localparam int SLICE_W = clog2_min1(N_SLICE);
  localparam int TMR_W   = clog2_min1(SCROLL_CYCLES);
  localparam int PAD_W   = (2 ** SLICE_W) * N_LEDS;

  logic [3:0] sw_raw;
  logic [3:0] press;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw
      switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Raw  (sw_raw[gi]),
        .o_Level(),
        .o_Press(press[gi])
      );
    end
  endgenerate

  mode_t              mode_reg;
  mode_t              ret_mode_reg;
  logic [SRC_W-1:0]   src_reg;
  logic [SLICE_W-1:0] slice_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic [N_LEDS-1:0]  snapshot_reg;
  logic [N_LEDS-1:0]  led_reg;

  // Selector tables are padded to a power of two so any index value is legal;
  // unused entries and bits past DATA_W read as zero.
  logic [DATA_W-1:0] src_words [2**SRC_W];
  logic [PAD_W-1:0]  sel_padded;
  logic [N_LEDS-1:0] slices [2**SLICE_W];
  logic [N_LEDS-1:0] live_slice;

  generate
    for (gi = 0; gi < 2 ** SRC_W; gi++) begin : g_src
      if (gi < N_SRC) begin : g_used
        assign src_words[gi] = i_Src_Bus[gi*DATA_W +: DATA_W];
      end else begin : g_pad
        assign src_words[gi] = '0;
      end
    end
    for (gi = 0; gi < 2 ** SLICE_W; gi++) begin : g_slice
      assign slices[gi] = sel_padded[gi*N_LEDS +: N_LEDS];
    end
  endgenerate

  assign sel_padded = PAD_W'(src_words[src_reg]);
  assign live_slice = slices[slice_reg];

  logic [SRC_W-1:0]   src_inc;
  logic [SLICE_W-1:0] slice_inc;
  logic               slice_last;
  logic               manual;

  assign src_inc    = (src_reg == SRC_W'(N_SRC - 1)) ? '0 : src_reg + SRC_W'(1);
  assign slice_last = (slice_reg == SLICE_W'(N_SLICE - 1));
  assign slice_inc  = slice_last ? '0 : slice_reg + SLICE_W'(1);
  assign manual     = press[0] | press[1] | press[2];

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_reg     <= MODE_LIVE;
      ret_mode_reg <= MODE_LIVE;
      src_reg      <= '0;
      slice_reg    <= '0;
      timer_reg    <= '0;
      snapshot_reg <= '0;
      led_reg      <= '0;
    end else begin
      case (mode_reg)
        MODE_FREEZE: begin
          if (press[3]) begin
            mode_reg  <= ret_mode_reg;
            timer_reg <= '0;
            led_reg   <= live_slice;
          end else begin
            led_reg <= snapshot_reg;
          end
        end
        default: begin
          if (press[3]) begin
            // Capture what the user is looking at; the LEDs simply hold.
            mode_reg     <= MODE_FREEZE;
            ret_mode_reg <= mode_reg;
            snapshot_reg <= led_reg;
          end else begin
            led_reg <= live_slice;
            if (press[2]) begin
              mode_reg <= (mode_reg == MODE_LIVE) ? MODE_SCROLL : MODE_LIVE;
            end
            if (press[0]) begin
              src_reg   <= src_inc;
              slice_reg <= '0;
            end else if (press[1]) begin
              slice_reg <= slice_inc;
            end
            if (manual) begin
              timer_reg <= '0;
            end else if (mode_reg == MODE_SCROLL) begin
              if (timer_reg == TMR_W'(SCROLL_CYCLES - 1)) begin
                timer_reg <= '0;
                slice_reg <= slice_inc;
                if (slice_last) begin
                  src_reg <= src_inc;
                end
              end else begin
                timer_reg <= timer_reg + TMR_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

  assign o_LED       = led_reg;
  assign o_Src_Sel   = src_reg;
  assign o_Slice_Sel = slice_reg;
  assign o_Mode      = mode_reg;

endmodule

// File: tb/tb_led_debug_view.sv
// Randomized self-checking bench for led_debug_view against a cycle-level
// behavioural model (sliding-window debounce, flat scroll position).
module tb_led_debug_view;

  localparam int DATA_W  = 8;
  localparam int N_SRC   = 3;
  localparam int N_LEDS  = 4;
  localparam int DEB     = 4;
  localparam int SCR     = 8;
  localparam int N_SLICE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] bus = 24'hC35AA7;
  logic [3:0]  sw  = 4'b0000;
  logic [3:0]  led;
  logic [1:0]  src_sel;
  logic [0:0]  slice_sel;
  logic [1:0]  mode;

  always #5 clk = ~clk;

  led_debug_view #(
    .DATA_W(DATA_W), .N_SRC(N_SRC), .N_LEDS(N_LEDS),
    .DEBOUNCE_CYCLES(DEB), .SCROLL_CYCLES(SCR)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Src_Bus(bus),
    .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
    .o_LED(led), .o_Src_Sel(src_sel), .o_Slice_Sel(slice_sel), .o_Mode(mode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: modes 0 LIVE, 1 SCROLL, 2 FREEZE
  int m_mode, m_ret, m_src, m_slice, m_timer, m_snap, m_led;
  bit m_level [4];
  bit m_press [4];
  bit m_hist  [4][DEB+2];

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slice_val(input logic [23:0] b, input int s, input int sl);
    int w;
    w = int'((b >> (s * DATA_W)) & 24'hFF);
    return (w >> (sl * N_LEDS)) & 15;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ret = 0; m_src = 0; m_slice = 0; m_timer = 0; m_snap = 0; m_led = 0;
    for (int k = 0; k < 4; k++) begin
      m_level[k] = 0;
      m_press[k] = 0;
      for (int j = 0; j < DEB + 2; j++) m_hist[k][j] = 0;
    end
  endtask

  task automatic model_edge();
    int pos;
    bit man;
    int new_led;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == 2) begin
      if (m_press[3]) begin
        m_mode = m_ret; m_timer = 0; m_led = slice_val(bus, m_src, m_slice);
      end else begin
        m_led = m_snap;
      end
    end else if (m_press[3]) begin
      m_ret = m_mode; m_snap = m_led; m_mode = 2;
    end else begin
      man = m_press[0] | m_press[1] | m_press[2];
      new_led = slice_val(bus, m_src, m_slice);
      if (man) begin
        if (m_press[2]) m_mode = 1 - m_mode;
        if (m_press[0]) begin
          m_src = (m_src + 1) % N_SRC; m_slice = 0;
        end else if (m_press[1]) begin
          m_slice = (m_slice + 1) % N_SLICE;
        end
        m_timer = 0;
      end else if (m_mode == 1) begin
        m_timer++;
        if (m_timer == SCR) begin
          m_timer = 0;
          pos = (m_src * N_SLICE + m_slice + 1) % (N_SRC * N_SLICE);
          m_src = pos / N_SLICE;
          m_slice = pos % N_SLICE;
        end
      end
      m_led = new_led;
    end
    // A level is accepted once DEB consecutive synchronised samples disagree with it
    for (int k = 0; k < 4; k++) begin
      bit all_diff;
      for (int j = DEB + 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = sw[k];
      all_diff = 1;
      for (int j = 2; j <= DEB + 1; j++) if (m_hist[k][j] == m_level[k]) all_diff = 0;
      m_press[k] = 0;
      if (all_diff) begin
        m_level[k] = !m_level[k];
        m_press[k] = m_level[k];
      end
    end
  endtask

  task automatic compare_all();
    check_val("led", 32'(led), m_led);
    check_val("src_sel", 32'(src_sel), m_src);
    check_val("slice_sel", 32'(slice_sel), m_slice);
    check_val("mode", 32'(mode), m_mode);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic idle_rand(input int n);
    repeat (n) begin
      if ($urandom_range(0, 3) == 0) bus = 24'($urandom);
      cycle();
    end
  endtask

  task automatic hold_sw(input logic [3:0] mask, input int n);
    sw = mask;
    repeat (n) cycle();
    sw = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw  = 4'b0000;
    #1;
    model_reset();
    compare_all();
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic wait_mode(input int target, input int budget);
    int n;
    n = 0;
    while (mode !== 2'(target) && n < budget) begin
      cycle();
      n++;
    end
    check_val("wait_mode", 32'(mode), target);
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check_val("rst_release_led", 32'(led), 7);
    check_val("rst_release_mode", 32'(mode), 0);

    hold_sw(4'b0001, 2);  idle(10);
    check_val("glitch_src", 32'(src_sel), 0);
    hold_sw(4'b0001, 8);  idle(10);
    check_val("sw1_src", 32'(src_sel), 1);
    check_val("sw1_led", 32'(led), 4'hA);
    hold_sw(4'b0010, 8);  idle(10);
    check_val("sw2_slice", 32'(slice_sel), 1);
    check_val("sw2_led", 32'(led), 4'h5);
    hold_sw(4'b0001, 8);  idle(4);
    check_val("src2_led", 32'(led), 4'h3);

    hold_sw(4'b0100, 8);  idle(2);
    check_val("scroll_mode", 32'(mode), 1);
    begin
      int n;
      n = 0;
      while (led !== 4'hC && n < 40) begin
        cycle();
        n++;
      end
      check_val("wait_led_c", 32'(led), 4'hC);
    end
    hold_sw(4'b1000, 6);  idle(2);
    bus[23:16] = 8'hFF;
    idle(20);
    check_val("freeze_mode", 32'(mode), 2);
    check_val("freeze_led", 32'(led), 4'hC);
    hold_sw(4'b0001, 8);  idle(6);
    hold_sw(4'b0010, 8);  idle(6);
    check_val("freeze_src", 32'(src_sel), 2);
    check_val("freeze_slice", 32'(slice_sel), 1);
    hold_sw(4'b1000, 8);
    wait_mode(1, 20);
    cycle();
    check_val("resume_led", 32'(led), 4'hF);
    idle(5);
    do_reset();

    bus = 24'hC35AA7;
    idle(3);
    hold_sw(4'b1001, 8);  idle(10);
    check_val("sw4_sw1_mode", 32'(mode), 2);
    check_val("sw4_sw1_src", 32'(src_sel), 0);
    hold_sw(4'b1000, 8);  idle(10);
    hold_sw(4'b0011, 8);  idle(10);
    check_val("sw1_sw2_src", 32'(src_sel), 1);
    check_val("sw1_sw2_slice", 32'(slice_sel), 0);

    for (int it = 0; it < 250; it++) begin
      logic [3:0] mask;
      if ($urandom_range(0, 99) < 3) do_reset();
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) != 0) mask = 4'(1 << $urandom_range(0, 3));
      if (mask[3] && $urandom_range(0, 1) == 0) mask[3] = 1'b0;
      if (mask == 4'b0000) mask = 4'b0100;
      hold_sw(mask, $urandom_range(1, 9));
      idle_rand($urandom_range(0, 14));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_debug_view.md
Name: led_debug_view

Overview:
- Parametrised board-level observation block between the CPU's debug buses (ALU out, regA, regB, and others) and the board LEDs/switches.
- Replaces the fixed "regA low nibble on four LEDs" mapping.
- Debounces the four board switches. Lets the user step through sources and slices, auto-scroll through every slice of every source, or freeze a snapshot.
- All LED outputs are registered.

Parameters:
- DATA_W, 8, width of each observed source bus.
- N_SRC, 3, number of source buses packed into i_Src_Bus (>=1).
- N_LEDS, 4, number of LEDs driven (1..DATA_W).
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required before a switch level is accepted (>=2).
- SCROLL_CYCLES, 25000000, clocks per auto-scroll step (>=2).
- Derived: N_SLICE = ceil(DATA_W/N_LEDS).

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset; asynchronous, active-high.
- i_Src_Bus  in  N_SRC*DATA_W  packed sources; source k = bits [k*DATA_W +: DATA_W].
- i_Switch_1  in  1  raw switch: next source.
- i_Switch_2  in  1  raw switch: next slice.
- i_Switch_3  in  1  raw switch: toggle LIVE/SCROLL.
- i_Switch_4  in  1  raw switch: toggle freeze.
- o_LED  out  N_LEDS  displayed bits; LSB = o_LED[0].
- o_Src_Sel  out  clog2(N_SRC) (min 1)  current source index.
- o_Slice_Sel  out  clog2(N_SLICE) (min 1)  current slice index.
- o_Mode  out  2  mode encoding: 0 LIVE, 1 SCROLL, 2 FREEZE.

Behaviour:
- Reset (async, i_Rst=1):
  - o_LED=0, o_Src_Sel=0, o_Slice_Sel=0, o_Mode=LIVE.
  - Debouncers: level=0, counter=0.
  - Scroll timer=0; snapshot=0; saved return mode=LIVE.
- Reset mid-operation aborts everything immediately; no press events occur in the first cycle after release.
- Debounce, per switch:
  - Raw input passes through a 2-flop synchroniser.
  - The counter increments while the synchronised value differs from the debounced level. It clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and still differs, the level flips and the counter clears.
  - Press event = one-cycle pulse on a 0->1 transition of the debounced level. Release generates nothing.
  - Latency from a stable raw edge to the press pulse = 2 + DEBOUNCE_CYCLES clocks.
- Slice s covers source bits [s*N_LEDS +: N_LEDS]. Bits beyond DATA_W read as 0 (zero-padded last slice).
- Mode FSM:
  - LIVE:
    - SW3 press -> SCROLL, scroll timer cleared.
    - SW4 press -> FREEZE; snapshot <= currently displayed slice value; return mode <= LIVE.
  - SCROLL:
    - SW3 press -> LIVE.
    - SW4 press -> FREEZE; return mode <= SCROLL.
    - When the timer reaches SCROLL_CYCLES-1: timer <= 0 and slice+1.
    - If the slice was N_SLICE-1: slice <= 0 and src <= (src+1) mod N_SRC.
  - FREEZE:
    - SW4 press -> saved return mode, with the scroll timer cleared.
    - SW1, SW2, SW3 presses are ignored; the scroll timer is held.
- Selection (LIVE/SCROLL only):
  - SW1 press: src <= (src+1) mod N_SRC, slice <= 0, timer cleared.
  - SW2 press: slice <= (slice+1) mod N_SLICE, timer cleared.
- Simultaneous events in one cycle:
  - SW4 beats everything; all other events that cycle are discarded.
  - Otherwise SW3 is applied, and SW1/SW2 are still applied.
  - SW1 beats SW2 (slice goes to 0).
  - A manual press beats a scroll tick (tick discarded, timer cleared).
- Output:
  - LIVE/SCROLL: o_LED <= selected slice of i_Src_Bus every cycle. Latency is 1 clock from i_Src_Bus and 1 clock after a selection register changes.
  - FREEZE: o_LED = snapshot, held regardless of i_Src_Bus.
  - o_Src_Sel, o_Slice_Sel and o_Mode are the registers themselves (no extra delay).
- Wrap-around: N_SRC=1 -> SW1 only resets slice. N_SLICE=1 -> SW2 is a no-op and scroll advances source every step.

Decomposition:
- Shared package (debug_view_pkg) holds:
  - the mode enum (LIVE/SCROLL/FREEZE) with its 2-bit encoding;
  - a clog2-with-minimum-1 helper;
  - the N_SLICE derivation function.
- One sub-module: switch_debounce. It takes i_Clk, i_Rst, raw input and parameter DEBOUNCE_CYCLES, and outputs the debounced level and press pulse. It is instantiated four times.
- FSM, selection counters, scroll timer and output mux are in led_debug_view.

Test Plan:
Bench parameters: DATA_W=8, N_LEDS=4, N_SRC=3, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8; sources = {0xC3, 0x5A, 0xA7} (src2, src1, src0).
1. Reset then release, LIVE -> o_LED=0x7 after 1 clock, Src_Sel=0, Slice_Sel=0, Mode=0. Assert i_Rst mid-scroll -> all outputs 0 the same cycle.
2. SW1 held 2 clocks then released -> no change. SW1 held 8 clocks -> exactly one press; Src_Sel=1, o_LED=0xA. SW2 press -> Slice_Sel=1, o_LED=0x5.
3. SW3 press at src2 slice0 -> SCROLL. o_LED shows 0x3 for 8 clocks, then 0xC, then wrap to src0 slice0 0x7.
4. SW4 press in SCROLL with o_LED=0xC, then change src2 to 0xFF -> o_LED stays 0xC. SW1/SW2 presses are ignored. Second SW4 press -> back to SCROLL, timer restarted, o_LED=0xF.
5. SW4 and SW1 press same cycle in LIVE -> FREEZE entered, Src_Sel unchanged. SW1 and SW2 same cycle -> src+1, slice=0. Manual press on a scroll-tick cycle -> only the press is applied.
